// File: rtl/data_memory_wait_if.sv
// Request/response bundle between the pipeline memory stage and data_memory_wait.
// The pipeline side is the master; the memory block is the slave.
interface data_memory_wait_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic [ADDR_W-1:0] i_req_addr;
    logic [WORD_W-1:0] i_req_wr_data;
    logic              i_req_wr_en;
    logic [1:0]        i_req_count;
    logic [WORD_W-1:0] o_res_rd_data;
    logic [1:0]        o_res_code;

    modport master (
        output i_req_addr,
        output i_req_wr_data,
        output i_req_wr_en,
        output i_req_count,
        input  o_res_rd_data,
        input  o_res_code
    );

    modport slave (
        input  i_req_addr,
        input  i_req_wr_data,
        input  i_req_wr_en,
        input  i_req_count,
        output o_res_rd_data,
        output o_res_code
    );
endinterface

// File: rtl/data_memory_wait.sv
// Byte-addressed little-endian word store with sized accesses, programmable wait
// states and a PENDING/DONE/ERROR response code that stalls the pipeline.
module data_memory_wait #(
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int WORD_COUNT     = 16,
    parameter int LATENCY        = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic clk,
    input logic areset,
    data_memory_wait_if.slave bus
);
    localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(4 * WORD_COUNT);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              wen_q;
    logic [1:0]        count_q;
    logic              err_q;
    logic [WORD_W-1:0] rd_q;
    logic [1:0]        res_code;

    logic [WORD_W-1:0] mem [0:WORD_COUNT-1];

    logic [ADDR_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_wen;
    logic [1:0]        acc_count;
    logic              acc_err;
    logic              accept;
    logic              enter_resp;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        byte_en;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] rd_word;

    // With LATENCY=0 the access completes on the accepting edge, so the live
    // inputs are used in IDLE and the latched copy everywhere else.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wen   = wen_q;
        acc_count = count_q;
        if (state_q == ST_IDLE) begin
            acc_addr  = bus.i_req_addr;
            acc_wdata = bus.i_req_wr_data;
            acc_wen   = bus.i_req_wr_en;
            acc_count = bus.i_req_count;
        end
        acc_err = ((acc_count == 2'd2) && acc_addr[0])
               || ((acc_count == 2'd3) && (acc_addr[1:0] != 2'b00))
               || ({1'b0, acc_addr} >= LIMIT);
        accept  = (state_q == ST_IDLE) && (bus.i_req_count != 2'd0);
        idx     = acc_addr[IDX_W+1:2];
    end

    always_comb begin
        state_d  = state_q;
        res_code = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                res_code = 2'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                res_code = err_q ? 2'd3 : 2'd2;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    end

    always_comb begin
        byte_en  = 4'b0000;
        wr_word  = acc_wdata;
        cur_word = mem[idx];
        rd_word  = '0;
        case (acc_count)
            2'd1: begin
                byte_en = 4'b0001 << acc_addr[1:0];
                wr_word = {4{acc_wdata[7:0]}};
                rd_word = {24'b0, cur_word[{acc_addr[1:0], 3'b000} +: 8]};
            end
            2'd2: begin
                byte_en = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{acc_wdata[15:0]}};
                rd_word = acc_addr[1] ? {16'b0, cur_word[31:16]} : {16'b0, cur_word[15:0]};
            end
            2'd3: begin
                byte_en = 4'b1111;
                rd_word = cur_word;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            count_q <= 2'd0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.i_req_addr;
                wdata_q <= bus.i_req_wr_data;
                wen_q   <= bus.i_req_wr_en;
                count_q <= bus.i_req_count;
                err_q   <= acc_err;
                cnt_q   <= 4'(LATENCY);
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rd_q <= (acc_err || acc_wen) ? '0 : rd_word;
            end
        end
    end

    // Storage only sees the reset when clearing is enabled.
    if (CLEAR_ON_RESET) begin : g_clear
        always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
                for (int w = 0; w < WORD_COUNT; w++) begin
                    mem[w] <= '0;
                end
            end else if (enter_resp && acc_wen && !acc_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
                    end
                end
            end
        end
    end else begin : g_keep
        always_ff @(posedge clk) begin
            if (!areset && enter_resp && acc_wen && !acc_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.o_res_code    = res_code;
    assign bus.o_res_rd_data = rd_q;
endmodule
